// File: rtl/store_unit_pkg.sv
// Shared types and helpers for the store unit: access-size encodings, FSM state codes,
// and alignment helpers used on the request path.
package store_unit_pkg;

    localparam logic [1:0] ST_SEL_BYTE = 2'd0;
    localparam logic [1:0] ST_SEL_HALF = 2'd1;
    localparam logic [1:0] ST_SEL_WORD = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRdReq,
        StRdWait
    } state_e;

    // The reserved size code 2'b11 behaves exactly like a word store.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == ST_SEL_BYTE || size == ST_SEL_HALF) ? size : ST_SEL_WORD;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [1:0] sz;
        sz = norm_size(size);
        if (sz == ST_SEL_BYTE) begin
            return 1'b0;
        end else if (sz == ST_SEL_HALF) begin
            return addr_lo[0];
        end
        return |addr_lo;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Request and data-memory port bundle of the store unit. The slave view belongs to the
// store unit; the master view is the MEM stage plus the memory it talks to.
interface store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;

    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    logic        done;
    logic        misalign;
    logic [31:0] bad_addr;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready, mem_rdata, mem_rvalid,
        output req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_be, done, misalign,
        bad_addr
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready, mem_rdata, mem_rvalid,
        input  req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_be, done, misalign,
        bad_addr
    );

endinterface

// File: rtl/store_unit_lane.sv
// Combinational lane placement: replicates store data across byte lanes, builds byte
// enables, and merges the selected lanes into an old word for read-modify-write.
module store_unit_lane
    import store_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] data_i,
    input  logic [31:0] old_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] merged_o
);

    logic [1:0]  lane;
    logic [31:0] mask;

    always_comb begin
        lane = BIG_ENDIAN ? (2'd3 - addr_lo_i) : addr_lo_i;
        wdata_o = data_i;
        be_o = 4'hf;
        unique case (norm_size(size_i))
            ST_SEL_BYTE: begin
                wdata_o = {4{data_i[7:0]}};
                be_o = 4'b0001 << lane;
            end
            ST_SEL_HALF: begin
                wdata_o = {2{data_i[15:0]}};
                be_o = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_o = data_i;
                be_o = 4'hf;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be_o[i]}};
        end
        merged_o = (old_i & ~mask) | (wdata_o & mask);
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: narrows register data onto byte lanes and drives a valid/ready memory port,
// falling back to read-modify-write for sub-word stores when memory lacks byte enables.
module store_unit
    import store_unit_pkg::*;
#(
    parameter bit USE_BE     = 1'b1,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    store_unit_if.slave bus
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  size_q, size_d;
    logic        done_q, done_d;
    logic        misalign_q, misalign_d;
    logic [31:0] bad_addr_q, bad_addr_d;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic [31:0] lane_merged;

    store_unit_lane #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_lane (
        .addr_lo_i(addr_q[1:0]),
        .size_i   (size_q),
        .data_i   (data_q),
        .old_i    (bus.mem_rdata),
        .wdata_o  (lane_wdata),
        .be_o     (lane_be),
        .merged_o (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            data_q     <= '0;
            size_q     <= ST_SEL_BYTE;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            size_q     <= size_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        size_d     = size_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        misalign_d = 1'b1;
                        bad_addr_d = bus.req_addr;
                    end else begin
                        addr_d = bus.req_addr;
                        data_d = bus.req_data;
                        size_d = norm_size(bus.req_size);
                        state_d = (USE_BE || norm_size(bus.req_size) == ST_SEL_WORD) ?
                                  StWrite : StRdReq;
                    end
                end
            end
            StWrite: begin
                if (bus.mem_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StRdReq: begin
                if (bus.mem_ready) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                // Merged word becomes a plain word store, so WRITE needs no RMW special case.
                if (bus.mem_rvalid) begin
                    data_d  = lane_merged;
                    size_d  = ST_SEL_WORD;
                    state_d = StWrite;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == StIdle) && !rst;
        bus.mem_valid = (state_q == StWrite || state_q == StRdReq) && !rst;
        bus.mem_we    = bus.mem_valid && (state_q == StWrite);
        bus.mem_addr  = bus.mem_valid ? {addr_q[31:2], 2'b00} : 32'h0;
        bus.mem_wdata = bus.mem_we ? lane_wdata : 32'h0;
        bus.mem_be    = 4'h0;
        if (bus.mem_valid) begin
            bus.mem_be = bus.mem_we ? lane_be : 4'hf;
        end
        bus.done      = done_q;
        bus.misalign  = misalign_q;
        bus.bad_addr  = bad_addr_q;
    end

endmodule
